// File: rtl/count_tick_controller.sv
// Run/pause/step sequencer producing single-cycle count enables at one of two
// programmable rates, entirely within the clk_in domain.
module count_tick_controller #(
  parameter int unsigned SLOW_DIV = 49999999,
  parameter int unsigned FAST_DIV = 4999,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        fast_sel,
  output logic        tick,
  output logic [1:0]  state,
  output logic        running,
  output logic [15:0] tick_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] SLOW_LIM = CNT_W'(SLOW_DIV);
  localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(FAST_DIV);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             fast_q_reg;
  logic             tick_reg, tick_next;
  logic [15:0]      tick_cnt_reg, tick_cnt_next;

  logic [CNT_W-1:0] limit;
  logic             rate_chg;

  assign limit    = fast_sel ? FAST_LIM : SLOW_LIM;
  assign rate_chg = (fast_sel != fast_q_reg);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      fast_q_reg   <= 1'b0;
      tick_reg     <= 1'b0;
      tick_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      fast_q_reg   <= fast_sel;
      tick_reg     <= tick_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  // Prescaler action follows the current state, so a stop on the terminal
  // count still lets that tick out.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tick_next     = 1'b0;
    tick_cnt_next = tick_cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
        end else if (step) begin
          tick_next = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = PAUSE;
        end
        if (rate_chg) begin
          cnt_next = '0;
        end else if (cnt_reg == limit) begin
          cnt_next  = '0;
          tick_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next    = IDLE;
          cnt_next      = '0;
          tick_cnt_next = '0;
        end else if (start) begin
          state_next = RUN;
        end else if (step) begin
          tick_next = 1'b1;
        end
        if (rate_chg) begin
          cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (tick_next) begin
      tick_cnt_next = tick_cnt_reg + 16'd1;
    end
  end

  assign tick     = tick_reg;
  assign state    = state_reg;
  assign running  = (state_reg == RUN);
  assign tick_cnt = tick_cnt_reg;

endmodule

// File: tb/tb_count_tick_controller.sv
// Scoreboard bench for count_tick_controller: stimulus queues expected ticks
// (edge number and tick_cnt), a monitor pops and compares them.
module tb_count_tick_controller;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        fast_sel = 1'b0;
  logic        tick;
  logic [1:0]  state;
  logic        running;
  logic [15:0] tick_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit bulk = 1'b0;

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  count_tick_controller #(.SLOW_DIV(9), .FAST_DIV(2), .CNT_W(32)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .fast_sel (fast_sel),
    .tick     (tick),
    .state    (state),
    .running  (running),
    .tick_cnt (tick_cnt)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic expect_tick(input int at, input logic [15:0] c);
    exp_t e;
    e.at  = at;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic pulse(input logic a_start, input logic a_stop, input logic a_step, output int e);
    start = a_start;
    stop  = a_stop;
    step  = a_step;
    e     = cyc + 1;
    @(negedge clk_in);
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic drain(input int limit);
    int i = 0;
    while (sb.size() > 0 && i < limit) begin
      @(negedge clk_in);
      i++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d ticks still outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every tick must match the head of the scoreboard in both
  // edge number and tick_cnt; an expected tick that does not show is missing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst && !bulk) begin
        if (tick) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_tick: tick at edge %0d tick_cnt=%0d, expected no tick", cyc, tick_cnt);
          end else begin
            e = sb.pop_front();
            if (cyc != e.at || tick_cnt !== e.cnt) begin
              n_bad++;
              $display("FAIL tick: edge %0d cnt %0d, expected edge %0d cnt %0d", cyc, tick_cnt, e.at, e.cnt);
            end else begin
              $display("ok   tick: edge %0d cnt %0d", cyc, tick_cnt);
            end
          end
        end else if (sb.size() > 0 && cyc >= sb[0].at) begin
          e = sb.pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missing_tick: no tick at edge %0d, expected tick cnt %0d", cyc, e.cnt);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, e, j;
    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_state", state, 2'b00);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    check("rst_tick_cnt", tick_cnt, 0);
    rst = 1'b1;
    @(negedge clk_in);

    // 1: slow run, period 10
    pulse(1, 0, 0, k);
    check("t1_running", running, 1);
    expect_tick(k + 10, 16'd1);
    expect_tick(k + 20, 16'd2);
    expect_tick(k + 30, 16'd3);
    drain(40);
    pulse(0, 1, 0, e);
    check("t1_pause", state, 2'b10);
    pulse(0, 1, 0, e);
    check("t1_idle", state, 2'b00);
    check("t1_clear", tick_cnt, 0);

    // 2: fast run, pause with cnt=1, resume finishes the partial period
    fast_sel = 1'b1;
    repeat (2) @(negedge clk_in);
    pulse(1, 0, 0, k);
    expect_tick(k + 3, 16'd1);
    expect_tick(k + 6, 16'd2);
    wait_until(k + 6);
    pulse(0, 1, 0, e);
    check("t2_pause", state, 2'b10);
    repeat (20) @(negedge clk_in);
    pulse(1, 0, 0, j);
    check("t2_resume", running, 1);
    expect_tick(j + 2, 16'd3);
    wait_until(j + 2);
    pulse(0, 1, 0, e);
    check("t2_pause2", state, 2'b10);

    // 3: steps in PAUSE, then clear
    for (int i = 0; i < 3; i++) begin
      expect_tick(cyc + 1, 16'(4 + i));
      pulse(0, 0, 1, e);
      @(negedge clk_in);
    end
    check("t3_tick_cnt", tick_cnt, 6);
    check("t3_still_pause", state, 2'b10);
    pulse(0, 1, 0, e);
    check("t3_idle", state, 2'b00);
    check("t3_clear", tick_cnt, 0);

    // 4: rate switch mid-period restarts the prescaler
    fast_sel = 1'b0;
    repeat (2) @(negedge clk_in);
    pulse(1, 0, 0, k);
    wait_until(k + 4);
    fast_sel = 1'b1;
    expect_tick(k + 8, 16'd1);
    drain(10);

    // 5: step ignored in RUN; stop on terminal count; start+stop in PAUSE
    expect_tick(k + 11, 16'd2);
    pulse(0, 0, 1, e);
    expect_tick(k + 14, 16'd3);
    wait_until(k + 13);
    pulse(0, 1, 0, e);
    check("t5_pause", state, 2'b10);
    pulse(1, 1, 0, e);
    check("t5_idle", state, 2'b00);
    check("t5_clear", tick_cnt, 0);
    repeat (5) @(negedge clk_in);

    // 6a: asynchronous reset between edges
    pulse(1, 0, 0, k);
    wait_until(k + 2);
    @(posedge clk_in);
    #2;
    check("t6_pre_tick", tick, 1);
    check("t6_pre_cnt", tick_cnt, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_state", state, 2'b00);
    check("t6_rst_running", running, 0);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_cnt", tick_cnt, 0);
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);

    // 6b: tick_cnt wrap, 65535 steps held in IDLE then one more
    bulk = 1'b1;
    step = 1'b1;
    repeat (65535) @(negedge clk_in);
    step = 1'b0;
    @(negedge clk_in);
    bulk = 1'b0;
    check("t6_preload", tick_cnt, 16'hFFFF);
    expect_tick(cyc + 1, 16'd0);
    pulse(0, 0, 1, e);
    drain(5);
    check("t6_wrap", tick_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
